// File: rtl/sync_fifo_param_pkg.sv
// ============================================================================
// Module  : sync_fifo_param_pkg
// Brief   : Shared FIFO read-mode constants and a clog2 helper.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package sync_fifo_param_pkg;

   localparam int FIFO_STD  = 0;
   localparam int FIFO_FWFT = 1;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_param_ram.sv
// ============================================================================
// Module  : sync_fifo_ram
// Brief   : DEPTH x DATA_W storage, one write port and one read port on clk.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo_ram
   import sync_fifo_param_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 128,
   parameter int FWFT   = FIFO_STD,
   localparam int AW    = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [AW-1:0]     i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Storage is intentionally not reset; only the read register is.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   generate
      if (FWFT == FIFO_FWFT) begin : g_async_rd
         logic w_unused_rd;
         assign w_unused_rd = &{1'b0, rst, i_re};
         assign o_rdata     = r_mem[i_raddr];
      end else begin : g_reg_rd
         logic [DATA_W-1:0] r_rdata;
         always_ff @(posedge clk) begin
            if (rst) begin
               r_rdata <= '0;
            end else if (i_re) begin
               r_rdata <= r_mem[i_raddr];
            end
         end
         assign o_rdata = r_rdata;
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// ============================================================================
// Module  : sync_fifo_param
// Brief   : Single-clock parametrised FIFO with level, almost flags, FWFT
//           option and sticky overflow/underflow.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo_param
   import sync_fifo_param_pkg::*;
#(
   parameter int DATA_W    = 4,
   parameter int ADDR_W    = 7,
   parameter int AFULL_TH  = 120,
   parameter int AEMPTY_TH = 8,
   parameter int FWFT      = FIFO_STD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              winc,
   input  logic [DATA_W-1:0] wdata,
   input  logic              rinc,
   output logic [DATA_W-1:0] rdata,
   output logic              wfull,
   output logic              rempty,
   output logic [ADDR_W:0]   level,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              overflow,
   output logic              underflow
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] c_AFULL  = (ADDR_W + 1)'(AFULL_TH);
   localparam logic [ADDR_W:0] c_AEMPTY = (ADDR_W + 1)'(AEMPTY_TH);

   generate
      if (AFULL_TH < 1 || AFULL_TH > DEPTH || AEMPTY_TH < 0 || AEMPTY_TH >= DEPTH) begin : g_bad_threshold
         $error("sync_fifo_param: AFULL_TH must be 1..DEPTH and AEMPTY_TH 0..DEPTH-1");
      end
   endgenerate

   logic [ADDR_W:0] r_wptr;
   logic [ADDR_W:0] r_rptr;
   logic [ADDR_W:0] r_level;
   logic            r_wfull;
   logic            r_rempty;
   logic            r_afull;
   logic            r_aempty;
   logic            r_overflow;
   logic            r_underflow;

   logic            w_wr_ok;
   logic            w_rd_ok;
   logic [ADDR_W:0] w_wptr_nxt;
   logic [ADDR_W:0] w_rptr_nxt;
   logic [ADDR_W:0] w_level_nxt;

   // Accept decisions use only registered flags, so no input reaches a flag combinationally.
   assign w_wr_ok     = winc & ~r_wfull;
   assign w_rd_ok     = rinc & ~r_rempty;
   assign w_wptr_nxt  = r_wptr + {{ADDR_W{1'b0}}, w_wr_ok};
   assign w_rptr_nxt  = r_rptr + {{ADDR_W{1'b0}}, w_rd_ok};
   assign w_level_nxt = r_level + {{ADDR_W{1'b0}}, w_wr_ok} - {{ADDR_W{1'b0}}, w_rd_ok};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_level     <= '0;
         r_wfull     <= 1'b0;
         r_rempty    <= 1'b1;
         r_afull     <= 1'b0;
         r_aempty    <= 1'b1;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_wptr   <= w_wptr_nxt;
         r_rptr   <= w_rptr_nxt;
         r_level  <= w_level_nxt;
         // Same address with differing wrap bits means the writer is a full lap ahead.
         r_wfull  <= (w_wptr_nxt[ADDR_W] != w_rptr_nxt[ADDR_W]) &&
                     (w_wptr_nxt[ADDR_W-1:0] == w_rptr_nxt[ADDR_W-1:0]);
         r_rempty <= (w_wptr_nxt == w_rptr_nxt);
         r_afull  <= (w_level_nxt >= c_AFULL);
         r_aempty <= (w_level_nxt <= c_AEMPTY);
         if (winc && r_wfull) begin
            r_overflow <= 1'b1;
         end
         if (rinc && r_rempty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   sync_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .FWFT   (FWFT)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_wr_ok),
      .i_waddr (r_wptr[ADDR_W-1:0]),
      .i_wdata (wdata),
      .i_re    (w_rd_ok),
      .i_raddr (r_rptr[ADDR_W-1:0]),
      .o_rdata (rdata)
   );

   assign wfull        = r_wfull;
   assign rempty       = r_rempty;
   assign level        = r_level;
   assign almost_full  = r_afull;
   assign almost_empty = r_aempty;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// ============================================================================
// Module  : tb_sync_fifo_param
// Brief   : Directed bench for sync_fifo_param, standard and FWFT instances.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Standard-read instance
   logic       rst0, winc0, rinc0;
   logic [3:0] wdata0, rdata0;
   logic [2:0] level0;
   logic       wfull0, rempty0, afull0, aempty0, ovf0, udf0;

   // FWFT instance
   logic       rst1, winc1, rinc1;
   logic [3:0] wdata1, rdata1;
   logic [2:0] level1;
   logic       wfull1, rempty1, afull1, aempty1, ovf1, udf1;

   sync_fifo_param #(
      .DATA_W(4), .ADDR_W(2), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(0)
   ) dut0 (
      .clk(clk), .rst(rst0), .winc(winc0), .wdata(wdata0), .rinc(rinc0),
      .rdata(rdata0), .wfull(wfull0), .rempty(rempty0), .level(level0),
      .almost_full(afull0), .almost_empty(aempty0),
      .overflow(ovf0), .underflow(udf0)
   );

   sync_fifo_param #(
      .DATA_W(4), .ADDR_W(2), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(1)
   ) dut1 (
      .clk(clk), .rst(rst1), .winc(winc1), .wdata(wdata1), .rinc(rinc1),
      .rdata(rdata1), .wfull(wfull1), .rempty(rempty1), .level(level1),
      .almost_full(afull1), .almost_empty(aempty1),
      .overflow(ovf1), .underflow(udf1)
   );

   typedef struct {
      logic       rst;
      logic       winc;
      logic       rinc;
      logic [3:0] wdata;
      logic [2:0] level;
      logic       rempty;
      logic       wfull;
      logic       afull;
      logic       aempty;
      logic       ovf;
      logic       udf;
      logic [3:0] rdata;
   } vec_t;

   vec_t vecs[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic add(input logic r, input logic w, input logic rd, input logic [3:0] d,
                      input logic [2:0] lvl, input logic e, input logic f, input logic af,
                      input logic ae, input logic ov, input logic un, input logic [3:0] rdat);
      vec_t v;
      v.rst = r;  v.winc = w;  v.rinc = rd;  v.wdata = d;
      v.level = lvl;  v.rempty = e;  v.wfull = f;  v.afull = af;  v.aempty = ae;
      v.ovf = ov;  v.udf = un;  v.rdata = rdat;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   int msb_toggles;
   logic prev_msb;

   initial begin
      rst0 = 1'b1; winc0 = 1'b0; rinc0 = 1'b0; wdata0 = '0;
      rst1 = 1'b1; winc1 = 1'b0; rinc1 = 1'b0; wdata1 = '0;

      //   rst w r  d      lvl e f af ae ov un rdata
      // T1 reset with both requests active
      add(1, 1, 1, 4'hF, 0, 1, 0, 0, 1, 0, 0, 4'h0);
      add(1, 1, 1, 4'hF, 0, 1, 0, 0, 1, 0, 0, 4'h0);
      // T2 fill
      add(0, 1, 0, 4'hA, 1, 0, 0, 0, 1, 0, 0, 4'h0);
      add(0, 1, 0, 4'hB, 2, 0, 0, 0, 0, 0, 0, 4'h0);
      add(0, 1, 0, 4'hC, 3, 0, 0, 1, 0, 0, 0, 4'h0);
      add(0, 1, 0, 4'hD, 4, 0, 1, 1, 0, 0, 0, 4'h0);
      // T2 drain
      add(0, 0, 1, 4'h0, 3, 0, 0, 1, 0, 0, 0, 4'hA);
      add(0, 0, 1, 4'h0, 2, 0, 0, 0, 0, 0, 0, 4'hB);
      add(0, 0, 1, 4'h0, 1, 0, 0, 0, 1, 0, 0, 4'hC);
      add(0, 0, 1, 4'h0, 0, 1, 0, 0, 1, 0, 0, 4'hD);
      // T4 empty with write+read: write wins, underflow, rdata holds
      add(0, 1, 1, 4'h5, 1, 0, 0, 0, 1, 0, 1, 4'hD);
      add(0, 0, 1, 4'h0, 0, 1, 0, 0, 1, 0, 1, 4'h5);
      add(0, 0, 1, 4'h0, 0, 1, 0, 0, 1, 0, 1, 4'h5);
      // T3 refill, rejected write, then full with write+read
      add(0, 1, 0, 4'h1, 1, 0, 0, 0, 1, 0, 1, 4'h5);
      add(0, 1, 0, 4'h2, 2, 0, 0, 0, 0, 0, 1, 4'h5);
      add(0, 1, 0, 4'h3, 3, 0, 0, 1, 0, 0, 1, 4'h5);
      add(0, 1, 0, 4'h4, 4, 0, 1, 1, 0, 0, 1, 4'h5);
      add(0, 1, 0, 4'hF, 4, 0, 1, 1, 0, 1, 1, 4'h5);
      add(0, 1, 1, 4'hE, 3, 0, 0, 1, 0, 1, 1, 4'h1);
      add(0, 0, 1, 4'h0, 2, 0, 0, 0, 0, 1, 1, 4'h2);
      add(0, 0, 1, 4'h0, 1, 0, 0, 0, 1, 1, 1, 4'h3);
      add(0, 0, 1, 4'h0, 0, 1, 0, 0, 1, 1, 1, 4'h4);
      // T7 three stored with overflow set, then reset mid-operation
      add(0, 1, 0, 4'h6, 1, 0, 0, 0, 1, 1, 1, 4'h4);
      add(0, 1, 0, 4'h7, 2, 0, 0, 0, 0, 1, 1, 4'h4);
      add(0, 1, 0, 4'h8, 3, 0, 0, 1, 0, 1, 1, 4'h4);
      add(1, 0, 0, 4'h0, 0, 1, 0, 0, 1, 0, 0, 4'h0);
      add(0, 1, 0, 4'h9, 1, 0, 0, 0, 1, 0, 0, 4'h0);
      add(0, 0, 1, 4'h0, 0, 1, 0, 0, 1, 0, 0, 4'h9);

      for (int i = 0; i < vecs.size(); i++) begin
         rst0 = vecs[i].rst; winc0 = vecs[i].winc; rinc0 = vecs[i].rinc; wdata0 = vecs[i].wdata;
         tick();
         chk("level",        i, {5'd0, level0},  {5'd0, vecs[i].level});
         chk("rempty",       i, {7'd0, rempty0}, {7'd0, vecs[i].rempty});
         chk("wfull",        i, {7'd0, wfull0},  {7'd0, vecs[i].wfull});
         chk("almost_full",  i, {7'd0, afull0},  {7'd0, vecs[i].afull});
         chk("almost_empty", i, {7'd0, aempty0}, {7'd0, vecs[i].aempty});
         chk("overflow",     i, {7'd0, ovf0},    {7'd0, vecs[i].ovf});
         chk("underflow",    i, {7'd0, udf0},    {7'd0, vecs[i].udf});
         chk("rdata",        i, {4'd0, rdata0},  {4'd0, vecs[i].rdata});
      end

      // T5 wrap: prime two words, then stream ten with simultaneous read/write
      rst0 = 1'b1; winc0 = 1'b0; rinc0 = 1'b0;
      tick();
      rst0 = 1'b0;
      winc0 = 1'b1; wdata0 = 4'd0; tick();
      wdata0 = 4'd1; tick();
      chk("wrap_prime_level", 0, {5'd0, level0}, 8'd2);
      msb_toggles = 0;
      prev_msb = dut0.r_wptr[2];
      for (int i = 0; i < 10; i++) begin
         winc0 = 1'b1; rinc0 = 1'b1; wdata0 = 4'(i + 2);
         tick();
         chk("wrap_rdata", i, {4'd0, rdata0}, 8'(i));
         chk("wrap_level", i, {5'd0, level0}, 8'd2);
         if (dut0.r_wptr[2] != prev_msb) msb_toggles++;
         prev_msb = dut0.r_wptr[2];
      end
      winc0 = 1'b0;
      tick();
      chk("wrap_tail_rdata", 10, {4'd0, rdata0}, 8'd10);
      tick();
      chk("wrap_tail_rdata", 11, {4'd0, rdata0}, 8'd11);
      chk("wrap_tail_empty", 11, {7'd0, rempty0}, 8'd1);
      rinc0 = 1'b0;
      chk("wrap_msb_toggles", 0, {7'd0, (msb_toggles >= 2)}, 8'd1);

      // T6 FWFT: head word visible without a read request
      rst1 = 1'b1; tick();
      chk("fwft_reset_empty", 0, {7'd0, rempty1}, 8'd1);
      rst1 = 1'b0;
      winc1 = 1'b1; wdata1 = 4'd7; tick();
      winc1 = 1'b0;
      chk("fwft_empty",  0, {7'd0, rempty1}, 8'd0);
      chk("fwft_rdata",  0, {4'd0, rdata1},  8'd7);
      tick();
      chk("fwft_hold",   1, {4'd0, rdata1},  8'd7);
      chk("fwft_level",  1, {5'd0, level1},  8'd1);
      rinc1 = 1'b1; tick();
      rinc1 = 1'b0;
      chk("fwft_empty",  2, {7'd0, rempty1}, 8'd1);
      chk("fwft_level",  2, {5'd0, level1},  8'd0);
      winc1 = 1'b1; wdata1 = 4'd8; tick();
      wdata1 = 4'd9; tick();
      winc1 = 1'b0;
      chk("fwft_empty",  3, {7'd0, rempty1}, 8'd0);
      chk("fwft_rdata",  3, {4'd0, rdata1},  8'd8);
      rinc1 = 1'b1; tick();
      chk("fwft_rdata",  4, {4'd0, rdata1},  8'd9);
      chk("fwft_level",  4, {5'd0, level1},  8'd1);
      tick();
      rinc1 = 1'b0;
      chk("fwft_empty",  5, {7'd0, rempty1}, 8'd1);
      chk("fwft_underflow", 5, {7'd0, udf1}, 8'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
